vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Raster timing generator for the 1280x1024@60 pixel domain: runs on the 108 MHz PLL output and qualifies on the PLL `locked` flag, then produces hsync, vsync, data-enable and pixel coordinates for the video pipeline. It sits directly downstream of the pixel-clock PLL and upstream of the pixel generator / DAC output stage. Coordinates lead the sync/DE outputs by a fixed parameterised latency so a pipelined pixel source can stay aligned.

## Interface
- H_ACTIVE, 1280, visible pixels per line
- H_FP, 48, horizontal front porch (clocks)
- H_SYNC, 112, hsync width (clocks)
- H_BP, 248, horizontal back porch (clocks)
- V_ACTIVE, 1024, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 3, vsync width (lines)
- V_BP, 38, vertical back porch (lines)
- H_POL, 1, hsync active level
- V_POL, 1, vsync active level
- LEAD, 2, cycles by which req/x/y precede de/hsync/vsync (0..8)
- LOCK_WAIT, 16, consecutive synchronised-locked cycles before raster starts

- clk  in  1  pixel clock (PLL outclk)
- rst  in  1  asynchronous, active-high reset
- locked  in  1  PLL lock, asynchronous to clk
- req  out  1  pixel request: (x,y) is in the active area
- x  out  11  column of requested pixel
- y  out  11  row of requested pixel
- frame_start  out  1  one-cycle pulse with req at (0,0)
- de  out  1  data enable, aligned to hsync/vsync
- hsync  out  1  horizontal sync, level per H_POL
- vsync  out  1  vertical sync, level per V_POL
- running  out  1  high while in RUN state

## Operation
- `locked` passes through a 2-flop synchroniser (lk_s) before any use.
- States: WAIT -> SETTLE when lk_s=1; SETTLE counts lk_s-high cycles, -> RUN when count reaches LOCK_WAIT-1; lk_s=0 in SETTLE or RUN -> WAIT next cycle, settle counter cleared.
- Counters h_cnt (0..H_TOTAL-1, H_TOTAL = sum of H params = 1688) and v_cnt (0..V_TOTAL-1, V_TOTAL = 1066), both 11 bits. Held at 0 outside RUN. In RUN h_cnt increments every clock; at H_TOTAL-1 wraps to 0 and v_cnt increments; v_cnt wraps to 0 after V_TOTAL-1.
- Line order: active, FP, sync, BP; same for frame order in lines.
- Stage 1 (registered from counters): req = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE; x=h_cnt, y=v_cnt when req else held at last value; frame_start = (h_cnt==0 && v_cnt==0); hs_raw = h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; vs_raw = v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (changes only at h wrap).
- Delay line of LEAD stages carries {req, hs_raw, vs_raw}; its outputs drive de, hsync (xor ~H_POL), vsync (xor ~V_POL). LEAD=0 means de/hsync/vsync are coincident with req.
- Leaving RUN: counters reset to 0, stage-1 and all delay-line stages forced inactive in the same cycle; no partial line emitted afterwards.

## Timing
- Reset values: state WAIT, req=0, x=0, y=0, frame_start=0, de=0, running=0, hsync=~H_POL, vsync=~V_POL, counters and delay line cleared.
- running rises on first RUN cycle (counters at 0,0); req=1, x=0, y=0, frame_start=1 one cycle later; de first high LEAD cycles after that.
- Latency locked rise -> first req: 2 (sync) + LOCK_WAIT + 1 clocks.
- Lock loss: running falls 3 clocks after locked falls; outputs inactive the same cycle.
- Frame period 1688*1066 = 1,799,408 clocks; frame_start exactly once per frame.

## Structure
- Package vga_timing_pkg: SXGA default timing constants, derived H_TOTAL/V_TOTAL, coordinate width (11), state enum {WAIT, SETTLE, RUN}.
- Sub-module lock_qualifier: 2-flop synchroniser plus settle counter, outputs a single `run_en`; raster counters, stage 1 and delay line stay in vga_timing_gen.

## Test plan
- Reset then locked=1 held -> running high at clock 2+LOCK_WAIT after locked, req/frame_start at (0,0) one clock later, de high LEAD=2 clocks after req.
- One full line -> req high 1280 clocks, hsync high exactly 112 clocks starting 1328 clocks after line's first req, line period 1688.
- Full frame -> y reaches 1023 then req stays low 42 lines; vsync high 3 lines starting line 1025; next frame_start 1,799,408 clocks after first.
- Drop locked mid-line at (x=500,y=300) -> running/req/de low 3 clocks later, syncs inactive; relock restarts at (0,0) after settle.
- locked glitch shorter than LOCK_WAIT during SETTLE -> settle counter restarts, raster never starts until LOCK_WAIT clean cycles.
- Async rst asserted mid-frame with LEAD=0 and small params (H 8/2/2/2, V 4/1/1/1) -> all outputs to reset values immediately; de coincident with req after restart.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the 1280x1024@60 raster timing generator.
package vga_timing_pkg;

  localparam int COORD_W = 11;

  localparam int SXGA_H_ACTIVE = 1280;
  localparam int SXGA_H_FP     = 48;
  localparam int SXGA_H_SYNC   = 112;
  localparam int SXGA_H_BP     = 248;
  localparam int SXGA_V_ACTIVE = 1024;
  localparam int SXGA_V_FP     = 1;
  localparam int SXGA_V_SYNC   = 3;
  localparam int SXGA_V_BP     = 38;

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } run_state_t;

  function automatic int span_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int SXGA_H_TOTAL = span_total(SXGA_H_ACTIVE, SXGA_H_FP, SXGA_H_SYNC, SXGA_H_BP);
  localparam int SXGA_V_TOTAL = span_total(SXGA_V_ACTIVE, SXGA_V_FP, SXGA_V_SYNC, SXGA_V_BP);

endpackage

// File: rtl/lock_qualifier.sv
// Synchronises the PLL lock flag and only releases the raster after
// LOCK_WAIT consecutive synchronised-locked cycles.
module lock_qualifier
  import vga_timing_pkg::*;
#(
  parameter int LOCK_WAIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic locked,
  output logic run_en
);

  localparam int CNT_W = (LOCK_WAIT > 2) ? $clog2(LOCK_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_WAIT - 1);

  logic             sync1_r;
  logic             lk_s;
  run_state_t       state_r;
  run_state_t       state_nx;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nx;

  // two-flop synchroniser for the asynchronous lock flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b0;
      lk_s    <= 1'b0;
    end else begin
      sync1_r <= locked;
      lk_s    <= sync1_r;
    end
  end

  // state and settle counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= WAIT;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nx;
      cnt_r   <= cnt_nx;
    end
  end

  // next state: the WAIT->SETTLE cycle already counts as the first locked cycle
  always_comb begin
    state_nx = state_r;
    cnt_nx   = '0;
    case (state_r)
      WAIT: begin
        if (lk_s) begin
          if (LOCK_WAIT <= 1) begin
            state_nx = RUN;
          end else begin
            state_nx = SETTLE;
            cnt_nx   = CNT_W'(1);
          end
        end else begin
          state_nx = WAIT;
        end
      end
      SETTLE: begin
        if (!lk_s) begin
          state_nx = WAIT;
        end else if (cnt_r == CNT_LAST) begin
          state_nx = RUN;
        end else begin
          state_nx = SETTLE;
          cnt_nx   = cnt_r + 1'b1;
        end
      end
      RUN: begin
        if (!lk_s) begin
          state_nx = WAIT;
        end else begin
          state_nx = RUN;
        end
      end
      default: state_nx = WAIT;
    endcase
  end

  // run_en reflects the state being entered so the raster can clear in the same cycle
  assign run_en = (state_nx == RUN);

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: lock-qualified h/v counters, pixel request stage and
// a LEAD-deep delay line that aligns de/hsync/vsync behind the coordinates.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE  = SXGA_H_ACTIVE,
  parameter int   H_FP      = SXGA_H_FP,
  parameter int   H_SYNC    = SXGA_H_SYNC,
  parameter int   H_BP      = SXGA_H_BP,
  parameter int   V_ACTIVE  = SXGA_V_ACTIVE,
  parameter int   V_FP      = SXGA_V_FP,
  parameter int   V_SYNC    = SXGA_V_SYNC,
  parameter int   V_BP      = SXGA_V_BP,
  parameter logic H_POL     = 1'b1,
  parameter logic V_POL     = 1'b1,
  parameter int   LEAD      = 2,
  parameter int   LOCK_WAIT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               locked,
  output logic               req,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               frame_start,
  output logic               de,
  output logic               hsync,
  output logic               vsync,
  output logic               running
);

  localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [COORD_W-1:0] H_LAST  = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST  = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT   = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT   = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_BEG  = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END  = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_BEG  = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END  = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [COORD_W-1:0] ZERO    = COORD_W'(0);

  logic               run_en;
  logic               live_s;
  logic [COORD_W-1:0] h_cnt;
  logic [COORD_W-1:0] v_cnt;
  logic               act_s;
  logic               hs_raw_r;
  logic               vs_raw_r;
  logic [2:0]         st1_s;
  logic [2:0]         dl_out_s;

  lock_qualifier #(
    .LOCK_WAIT(LOCK_WAIT)
  ) u_lock_qualifier (
    .clk   (clk),
    .rst   (rst),
    .locked(locked),
    .run_en(run_en)
  );

  // running mirrors the RUN state; the first RUN cycle sees counters at (0,0)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running <= 1'b0;
    end else begin
      running <= run_en;
    end
  end

  assign live_s = run_en && running;

  // raster counters, parked at (0,0) until the raster is live
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= ZERO;
      v_cnt <= ZERO;
    end else if (!live_s) begin
      h_cnt <= ZERO;
      v_cnt <= ZERO;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= ZERO;
      v_cnt <= (v_cnt == V_LAST) ? ZERO : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign act_s = (h_cnt < H_ACT) && (v_cnt < V_ACT);

  // stage 1: pixel request, coordinates and raw sync windows
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req         <= 1'b0;
      x           <= ZERO;
      y           <= ZERO;
      frame_start <= 1'b0;
      hs_raw_r    <= 1'b0;
      vs_raw_r    <= 1'b0;
    end else if (live_s) begin
      req         <= act_s;
      frame_start <= (h_cnt == ZERO) && (v_cnt == ZERO);
      hs_raw_r    <= (h_cnt >= HS_BEG) && (h_cnt <= HS_END);
      vs_raw_r    <= (v_cnt >= VS_BEG) && (v_cnt <= VS_END);
      if (act_s) begin
        x <= h_cnt;
        y <= v_cnt;
      end
    end else begin
      req         <= 1'b0;
      frame_start <= 1'b0;
      hs_raw_r    <= 1'b0;
      vs_raw_r    <= 1'b0;
    end
  end

  assign st1_s = {req, hs_raw_r, vs_raw_r};

  generate
    if (LEAD == 0) begin : g_no_delay
      assign dl_out_s = st1_s;
    end else begin : g_delay
      logic [2:0] dl_r [LEAD];

      // LEAD-deep delay of {req, hs_raw, vs_raw}, flushed when the raster stops
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < LEAD; i++) dl_r[i] <= 3'b000;
        end else if (!run_en) begin
          for (int i = 0; i < LEAD; i++) dl_r[i] <= 3'b000;
        end else begin
          dl_r[0] <= st1_s;
          for (int i = 1; i < LEAD; i++) dl_r[i] <= dl_r[i-1];
        end
      end

      assign dl_out_s = dl_r[LEAD-1];
    end
  endgenerate

  assign de    = dl_out_s[2];
  assign hsync = dl_out_s[1] ^ ~H_POL;
  assign vsync = dl_out_s[0] ^ ~V_POL;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: an SXGA instance (LEAD=2) and a tiny-raster instance
// (LEAD=0, active-low hsync) checked every cycle against a timestamp-based model.
module tb_vga_timing_gen;

  localparam int A_HA = 1280, A_HF = 48, A_HS = 112, A_HB = 248;
  localparam int A_VA = 1024, A_VF = 1,  A_VS = 3,   A_VB = 38;
  localparam int A_LD = 2,    A_LW = 16;
  localparam logic A_HP = 1'b1, A_VP = 1'b1;

  localparam int B_HA = 8, B_HF = 2, B_HS = 2, B_HB = 2;
  localparam int B_VA = 4, B_VF = 1, B_VS = 1, B_VB = 1;
  localparam int B_LD = 0, B_LW = 4;
  localparam logic B_HP = 1'b0, B_VP = 1'b1;

  logic clk = 1'b0;
  logic rst_a, rst_b, locked_a, locked_b;
  logic req_a, fs_a, de_a, hsync_a, vsync_a, running_a;
  logic req_b, fs_b, de_b, hsync_b, vsync_b, running_b;
  logic [10:0] x_a, y_a, x_b, y_b;
  logic [27:0] act_a, act_b, exp_a, exp_b;

  int n_tests = 0;
  int n_fail  = 0;

  int m_streak [2];
  int m_sd1    [2];
  int m_sd2    [2];
  int m_t      [2];
  logic m_run  [2];
  logic [10:0] m_x [2];
  logic [10:0] m_y [2];

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
    .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
    .H_POL(A_HP), .V_POL(A_VP), .LEAD(A_LD), .LOCK_WAIT(A_LW)
  ) u_sxga (
    .clk(clk), .rst(rst_a), .locked(locked_a), .req(req_a), .x(x_a), .y(y_a),
    .frame_start(fs_a), .de(de_a), .hsync(hsync_a), .vsync(vsync_a), .running(running_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
    .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
    .H_POL(B_HP), .V_POL(B_VP), .LEAD(B_LD), .LOCK_WAIT(B_LW)
  ) u_small (
    .clk(clk), .rst(rst_b), .locked(locked_b), .req(req_b), .x(x_b), .y(y_b),
    .frame_start(fs_b), .de(de_b), .hsync(hsync_b), .vsync(vsync_b), .running(running_b)
  );

  assign act_a = {running_a, req_a, fs_a, de_a, hsync_a, vsync_a, x_a, y_a};
  assign act_b = {running_b, req_b, fs_b, de_b, hsync_b, vsync_b, x_b, y_b};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: raster runs once locked has been sampled high LOCK_WAIT times in a row
  // (seen two clocks late through the synchroniser); outputs follow from the
  // number of clocks t since running rose, as raster position t-1 (and t-1-LEAD).
  task automatic model_step(input int id, input logic r, input logic lk, output logic [27:0] e);
    int ha, hf, hs, va, vf, vs, ld, lw, ht, vt, p, q, ph, pv, qh, qv;
    logic hp, vp, prev, live, dl, rq, fs, de, hsy, vsy;
    if (id == 0) begin
      ha = A_HA; hf = A_HF; hs = A_HS; va = A_VA; vf = A_VF; vs = A_VS;
      ld = A_LD; lw = A_LW; hp = A_HP; vp = A_VP;
      ht = A_HA + A_HF + A_HS + A_HB; vt = A_VA + A_VF + A_VS + A_VB;
    end else begin
      ha = B_HA; hf = B_HF; hs = B_HS; va = B_VA; vf = B_VF; vs = B_VS;
      ld = B_LD; lw = B_LW; hp = B_HP; vp = B_VP;
      ht = B_HA + B_HF + B_HS + B_HB; vt = B_VA + B_VF + B_VS + B_VB;
    end
    if (r) begin
      m_streak[id] = 0; m_sd1[id] = 0; m_sd2[id] = 0;
      m_run[id] = 1'b0; m_t[id] = 0; m_x[id] = 11'd0; m_y[id] = 11'd0;
    end else begin
      m_sd2[id] = m_sd1[id];
      m_sd1[id] = m_streak[id];
      m_streak[id] = lk ? m_streak[id] + 1 : 0;
      prev = m_run[id];
      m_run[id] = (m_sd2[id] >= lw);
      if (m_run[id]) m_t[id] = prev ? m_t[id] + 1 : 0;
    end
    live = m_run[id] && (m_t[id] >= 1);
    p = live ? m_t[id] - 1 : 0;
    ph = p % ht; pv = (p / ht) % vt;
    rq = live && (ph < ha) && (pv < va);
    fs = live && (ph == 0) && (pv == 0);
    if (rq) begin
      m_x[id] = 11'(ph);
      m_y[id] = 11'(pv);
    end
    dl = m_run[id] && (m_t[id] >= ld + 1);
    q = dl ? m_t[id] - 1 - ld : 0;
    qh = q % ht; qv = (q / ht) % vt;
    de  = dl && (qh < ha) && (qv < va);
    hsy = (dl && (qh >= ha + hf) && (qh < ha + hf + hs)) ? hp : ~hp;
    vsy = (dl && (qv >= va + vf) && (qv < va + vf + vs)) ? vp : ~vp;
    e = {m_run[id], rq, fs, de, hsy, vsy, m_x[id], m_y[id]};
  endtask

  // per-cycle comparison of both instances against the model
  initial begin
    forever begin
      @(negedge clk);
      model_step(0, rst_a, locked_a, exp_a);
      model_step(1, rst_b, locked_b, exp_b);
      check("sxga_cycle", {4'd0, act_a}, {4'd0, exp_a});
      check("small_cycle", {4'd0, act_b}, {4'd0, exp_b});
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  initial begin
    int n, req_cnt, hs_cnt, hs_rise, de_rise, vs_cnt, vs_rise, fs_cnt, de_bad, max_y;
    logic prev_hs, prev_de, prev_vs;

    rst_a = 1'b1; rst_b = 1'b1; locked_a = 1'b0; locked_b = 1'b0;
    step(3);
    check("sxga_reset", {4'd0, act_a}, 32'h0000000);
    check("small_reset", {4'd0, act_b}, {4'd0, 6'b000010, 22'd0});
    rst_a = 1'b0; rst_b = 1'b0;
    step(2);

    // lock acquisition on the SXGA instance
    locked_a = 1'b1;
    n = 0;
    while (running_a !== 1'b1 && n < 40) begin step(1); n++; end
    check("sxga_running_latency", n, 18);
    while (req_a !== 1'b1 && n < 40) begin step(1); n++; end
    check("sxga_req_latency", n, 19);
    check("sxga_first_pixel", {29'd0, fs_a, (x_a == 11'd0), (y_a == 11'd0)}, 32'd7);
    while (de_a !== 1'b1 && n < 40) begin step(1); n++; end
    check("sxga_de_latency", n, 21);

    // one full line measured from the first de rise
    req_cnt = 32'(req_a); hs_cnt = 32'(hsync_a); hs_rise = -1; de_rise = -1;
    prev_hs = hsync_a; prev_de = de_a;
    for (int i = 1; i <= 1688; i++) begin
      step(1);
      if (i < 1688) begin
        req_cnt += 32'(req_a);
        hs_cnt  += 32'(hsync_a);
      end
      if (hsync_a && !prev_hs && hs_rise < 0) hs_rise = i;
      if (de_a && !prev_de && de_rise < 0) de_rise = i;
      prev_hs = hsync_a; prev_de = de_a;
    end
    check("sxga_line_req_count", req_cnt, 1280);
    check("sxga_line_hsync_count", hs_cnt, 112);
    check("sxga_hsync_offset", hs_rise, 1328);
    check("sxga_line_period", de_rise, 1688);

    // lose lock mid-line at x=500
    n = 0;
    while (!(req_a === 1'b1 && x_a == 11'd500) && n < 2000) begin step(1); n++; end
    check("sxga_reach_x500", {20'd0, x_a, req_a}, {20'd0, 11'd500, 1'b1});
    locked_a = 1'b0;
    step(2);
    check("sxga_still_running", {31'd0, running_a}, 32'd1);
    step(1);
    check("sxga_lock_loss", {4'd0, act_a}, {4'd0, 6'b000000, 11'd502, 11'd1});
    step(5);
    locked_a = 1'b1;
    n = 0;
    while (req_a !== 1'b1 && n < 40) begin step(1); n++; end
    check("sxga_relock_latency", n, 19);
    check("sxga_relock_origin", {29'd0, fs_a, (x_a == 11'd0), (y_a == 11'd0)}, 32'd7);

    // glitch on locked while the small instance is settling
    locked_b = 1'b1;
    step(3);
    locked_b = 1'b0;
    step(1);
    locked_b = 1'b1;
    n = 4;
    while (running_b !== 1'b1 && n < 40) begin step(1); n++; end
    check("small_glitch_restart", n, 10);

    // one full small frame from its frame_start
    n = 0;
    while (fs_b !== 1'b1 && n < 20) begin step(1); n++; end
    check("small_first_fs", {31'd0, fs_b}, 32'd1);
    req_cnt = 0; hs_cnt = 0; vs_cnt = 0; vs_rise = -1; fs_cnt = 0; de_bad = 0; max_y = 0;
    prev_vs = vsync_b;
    for (int i = 0; i < 98; i++) begin
      if (i > 0) step(1);
      req_cnt += 32'(req_b);
      hs_cnt  += 32'(hsync_b == 1'b0);
      vs_cnt  += 32'(vsync_b);
      fs_cnt  += 32'(fs_b);
      if (de_b !== req_b) de_bad++;
      if (req_b && 32'(y_b) > max_y) max_y = 32'(y_b);
      if (vsync_b && !prev_vs && vs_rise < 0) vs_rise = i;
      prev_vs = vsync_b;
    end
    step(1);
    check("small_frame_req_count", req_cnt, 32);
    check("small_frame_hsync_count", hs_cnt, 14);
    check("small_frame_vsync_count", vs_cnt, 14);
    check("small_vsync_offset", vs_rise, 70);
    check("small_fs_once", fs_cnt, 1);
    check("small_max_y", max_y, 3);
    check("small_de_coincident", de_bad, 0);
    check("small_frame_period", {31'd0, fs_b}, 32'd1);

    // asynchronous reset in the middle of a frame
    n = 0;
    while (!(req_b === 1'b1 && x_b == 11'd3 && y_b == 11'd2) && n < 200) begin step(1); n++; end
    check("small_reach_3_2", {20'd0, x_b, y_b[0]}, {20'd0, 11'd3, 1'b0});
    rst_b = 1'b1;
    #1;
    check("small_async_reset", {4'd0, act_b}, {4'd0, 6'b000010, 22'd0});
    step(2);
    rst_b = 1'b0;
    n = 0;
    while (req_b !== 1'b1 && n < 40) begin step(1); n++; end
    check("small_restart_latency", n, 7);
    check("small_restart_origin", {28'd0, de_b, fs_b, (x_b == 11'd0), (y_b == 11'd0)}, 32'd15);

    step(1800);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
